sum_accumulator: RTL and testbench

//   Downstream stage of the 8-bit ripple adder. Consumes its 9-bit sum word

---
 rtl/sum_accumulator.sv | 141 ++++++++++++++
 tb/tb_sum_accumulator.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// ============================================================================
//  Module   : sum_accumulator
//  Brief    : Accumulates N_SAMPLES adder sum words per frame and presents the
//             frame total on a valid/ready port. Optional SATURATE_EN macro
//             clamps the total at 2^ACC_W-1 and raises ovf.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sum_accumulator #(
    parameter int IN_W      = 9,
    parameter int ACC_W     = 11,
    parameter int N_SAMPLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [IN_W-1:0]  in_sum,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // Count value held while waiting for the final word of a frame.
    localparam logic [7:0] c_last_cnt = 8'(N_SAMPLES - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_next;
    logic [ACC_W-1:0] r_out_acc;
    logic [ACC_W-1:0] w_out_acc_next;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_next;
    logic             r_ovf;
    logic             w_ovf_next;

    logic             w_in_accept;
    logic             w_out_accept;
    logic             w_last;
    logic [ACC_W-1:0] w_in_ext;
    logic [ACC_W-1:0] w_base;
    logic [ACC_W-1:0] w_add_res;
    logic             w_add_ovf;

    assign in_ready     = !clear && (r_state != S_HOLD);
    assign out_valid    = (r_state == S_HOLD);
    assign busy         = (r_state != S_IDLE);
    assign out_acc      = r_out_acc;
    assign ovf          = r_ovf;

    assign w_in_accept  = in_valid & in_ready;
    assign w_out_accept = out_valid & out_ready;
    // cnt is 0 in IDLE, so this also covers the single-sample frame.
    assign w_last       = (r_cnt == c_last_cnt);
    assign w_in_ext     = ACC_W'(in_sum);
    assign w_base       = (r_state == S_IDLE) ? '0 : r_acc;

`ifdef SATURATE_EN
    logic [ACC_W:0] w_sum;
    assign w_sum     = {1'b0, w_base} + {1'b0, w_in_ext};
    assign w_add_ovf = w_sum[ACC_W];
    assign w_add_res = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_add_ovf = 1'b0;
    assign w_add_res = w_base + w_in_ext;
`endif

    always_comb begin
        w_state_next   = r_state;
        w_acc_next     = r_acc;
        w_cnt_next     = r_cnt;
        w_ovf_next     = r_ovf;
        w_out_acc_next = r_out_acc;
        if (clear) begin
            w_state_next = S_IDLE;
            w_acc_next   = '0;
            w_cnt_next   = '0;
            w_ovf_next   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_in_accept) begin
                        w_acc_next = w_add_res;
                        w_cnt_next = r_cnt + 8'd1;
                        w_ovf_next = r_ovf | w_add_ovf;
                        if (w_last) begin
                            w_state_next   = S_HOLD;
                            w_out_acc_next = w_add_res;
                        end else begin
                            w_state_next = S_ACCUM;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_out_accept) begin
                        w_state_next = S_IDLE;
                        w_acc_next   = '0;
                        w_cnt_next   = '0;
                        w_ovf_next   = 1'b0;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_acc_next   = '0;
                    w_cnt_next   = '0;
                    w_ovf_next   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_out_acc <= '0;
        end else begin
            r_state   <= w_state_next;
            r_acc     <= w_acc_next;
            r_cnt     <= w_cnt_next;
            r_ovf     <= w_ovf_next;
            r_out_acc <= w_out_acc_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sum_accumulator.sv
// ============================================================================
//  Module   : tb_sum_accumulator
//  Brief    : Scoreboard bench for sum_accumulator: directed frames, random
//             traffic, and a single-sample instance.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sum_accumulator;

    localparam int c_n = 8;

`ifdef SATURATE_EN
    localparam logic [10:0] c_exp3 = 11'h7FF;
    localparam logic        c_ovf3 = 1'b1;
`else
    localparam logic [10:0] c_exp3 = 11'h7F8;
    localparam logic        c_ovf3 = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic [8:0]  in_sum = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [10:0] out_acc;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        ovf;
    logic        busy;

    logic        clear1 = 1'b0;
    logic [8:0]  in_sum1 = '0;
    logic        in_valid1 = 1'b0;
    logic        in_ready1;
    logic [10:0] out_acc1;
    logic        out_valid1;
    logic        out_ready1 = 1'b0;
    logic        ovf1;
    logic        busy1;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned m_sum   = 0;
    int          m_cnt   = 0;
    logic [11:0] q_exp[$];

    always #5 clk = ~clk;

    sum_accumulator #(.IN_W(9), .ACC_W(11), .N_SAMPLES(c_n)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_sum(in_sum),
        .in_valid(in_valid), .in_ready(in_ready), .out_acc(out_acc),
        .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf), .busy(busy)
    );

    sum_accumulator #(.IN_W(9), .ACC_W(11), .N_SAMPLES(1)) dut1 (
        .clk(clk), .rst(rst), .clear(clear1), .in_sum(in_sum1),
        .in_valid(in_valid1), .in_ready(in_ready1), .out_acc(out_acc1),
        .out_valid(out_valid1), .out_ready(out_ready1), .ovf(ovf1), .busy(busy1)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: a frame total is the plain sum of its accepted words.
    task automatic push_expected();
`ifdef SATURATE_EN
        if (m_sum >= 2048) q_exp.push_back({1'b1, 11'h7FF});
        else               q_exp.push_back({1'b0, m_sum[10:0]});
`else
        q_exp.push_back({1'b0, m_sum[10:0]});
`endif
        m_sum = 0;
        m_cnt = 0;
    endtask

    task automatic cycle(input logic v, input logic [8:0] d, input logic orr,
                         input logic creq);
        @(negedge clk);
        in_valid  = v;
        in_sum    = d;
        out_ready = orr;
        clear     = creq && !out_valid;
        #1;
        if (clear) begin
            check("clear_blocks_in_ready", in_ready, 0);
            m_sum = 0;
            m_cnt = 0;
        end else if (in_valid && in_ready) begin
            m_sum += d;
            m_cnt++;
            if (m_cnt == c_n) push_expected();
        end
    endtask

    task automatic wait_out(input string name, input logic [10:0] exp_acc);
        int k;
        k = 0;
        while (!out_valid && k < 20) begin
            cycle(0, 0, 0, 0);
            k++;
        end
        check({name, "_seen"}, out_valid, 1);
        check({name, "_acc"}, out_acc, exp_acc);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        clear = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_acc", out_acc, 0);
        check("rst_ovf", ovf, 0);
        q_exp.delete();
        m_sum = 0;
        m_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every output handshake consumes one scoreboard entry.
    always @(negedge clk) begin
        #2;
        if (!rst && !clear && out_valid && out_ready) begin
            if (q_exp.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                logic [11:0] e;
                e = q_exp.pop_front();
                check("sb_out_acc", out_acc, e[10:0]);
                check("sb_ovf", ovf, e[11]);
            end
        end
    end

    initial begin
        #1;
        check("init_busy", busy, 0);
        check("init_out_valid", out_valid, 0);
        check("init_in_ready", in_ready, 1);
        check("init_out_acc", out_acc, 0);
        check("init_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a frame, then a clean frame of 8x10.
        for (int i = 0; i < 3; i++) cycle(1, 9'd7, 1, 0);
        check("mid_busy", busy, 1);
        rst_pulse();
        for (int i = 0; i < 8; i++) cycle(1, 9'd10, 1, 0);
        cycle(0, 0, 1, 0);
        check("t2_latency_valid", out_valid, 1);
        check("t2_acc", out_acc, 80);
        check("t2_ovf", ovf, 0);
        cycle(0, 0, 1, 0);
        check("t2_one_cycle", out_valid, 0);

        // Largest words: wrap or clamp depending on build.
        for (int i = 0; i < 8; i++) cycle(1, 9'h1FF, 1, 0);
        cycle(0, 0, 1, 0);
        check("t3_acc", out_acc, c_exp3);
        check("t3_ovf", ovf, c_ovf3);

        // Gapped input, then a stalled consumer.
        for (int i = 1; i <= 8; i++) begin
            cycle(1, 9'(i), 0, 0);
            cycle(0, 0, 0, 0);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1, 9'd99, 0, 0);
            check("t4_in_ready_low", in_ready, 0);
            check("t4_acc_stable", out_acc, 36);
            check("t4_valid_held", out_valid, 1);
        end
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        check("t4_released", out_valid, 0);

        // Abort a frame with clear while a word is offered.
        for (int i = 0; i < 4; i++) cycle(1, 9'd50, 1, 0);
        cycle(1, 9'd55, 1, 1);
        check("t5_clear_applied", clear, 1);
        cycle(0, 0, 1, 0);
        check("t5_busy_after_clear", busy, 0);
        for (int i = 0; i < 8; i++) cycle(1, 9'd2, 0, 0);
        wait_out("t5_frame", 11'd16);
        cycle(0, 0, 1, 0);

        // Single-sample instance.
        @(negedge clk);
        in_valid1 = 1'b1;
        in_sum1   = 9'h100;
        #1;
        check("t6_in_ready", in_ready1, 1);
        @(negedge clk);
        in_valid1  = 1'b0;
        out_ready1 = 1'b1;
        #1;
        check("t6_valid", out_valid1, 1);
        check("t6_acc", out_acc1, 256);
        check("t6_in_ready_hold", in_ready1, 0);
        @(negedge clk);
        #1;
        check("t6_back_idle", out_valid1, 0);
        check("t6_busy", busy1, 0);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, 9'($urandom_range(0, 511)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
        end
        for (int i = 0; i < 20; i++) cycle(0, 0, 1, 0);
        check("drain_queue_empty", q_exp.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
